can_bit_destuff: RTL and testbench
==================================

# can_bit_destuff

Receive-side bit-stream stage for the CAN controller, downstream of the bit-timing logic. Synchronises the raw CAN RX pin, generates the hard-sync pulse that bit timing consumes, samples the bus on each `sample_point`, and removes stuff bits. Emits one destuffed bit per valid sample to the frame decoder, and flags stuff errors, start of frame and bus idle.

## Interface
- `IDLE_BITS`, 11: consecutive recessive samples required to declare bus idle (integration / end of frame).
- `STUFF_LEN`, 5: equal-polarity run length after which a complementary stuff bit is expected.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_in` in 1: raw CAN RX pin, asynchronous. 1 = recessive.
- `sample_point` in 1: 1-cycle pulse from bit timing marking the sample instant.
- `stuff_en` in 1: from the frame decoder. 1 = stuffing region (SOF through CRC); read only in `sample_point` cycles.
- `rx_sync_edge` out 1: 1-cycle hard-sync pulse to bit timing.
- `bit_valid` out 1: 1-cycle strobe; `bit_data` holds a destuffed bit.
- `bit_data` out 1: destuffed bit value.
- `sof` out 1: 1-cycle pulse together with the SOF bit's `bit_valid`.
- `stuff_err` out 1: 1-cycle pulse on a stuff violation.
- `bus_idle` out 1: level, high while in IDLE.

## Operation
- **Input synchronisation.** `rx_in` passes through a 2-flop synchroniser to give `rx_s`. `rx_q` holds the previous value of `rx_s`. A falling edge is `rx_q & ~rx_s`.
- **Recessive counter `rec_cnt`.**
  - Width: $clog2(IDLE_BITS+1).
  - On a `sample_point` with `rx_s=1`: increment, saturating at `IDLE_BITS`.
  - On a `sample_point` with `rx_s=0`: clear to 0.
  - Active in all states.
- **Run tracking.** `run_bit` holds the current run polarity; `run_cnt` is 3 bits and saturates at `STUFF_LEN`.
- **States:**
  - **INTEGRATE** (reset state). When `rec_cnt` reaches `IDLE_BITS`, go to IDLE.
  - **IDLE.** `bus_idle=1`.
    - A falling edge on `rx_s` pulses `rx_sync_edge`.
    - A `sample_point` with `rx_s=0` does all of: pulse `sof`, pulse `bit_valid` with `bit_data=0`, set `run_bit=0`, `run_cnt=1`, go to RECEIVE.
  - **RECEIVE.** On each `sample_point`:
    - If `stuff_en=1` and `run_cnt==STUFF_LEN`, the sample is a stuff bit.
      - If `rx_s==run_bit`: pulse `stuff_err`, go to INTEGRATE.
      - Otherwise: discard (no `bit_valid`), set `run_bit=rx_s`, `run_cnt=1`.
    - Otherwise: pulse `bit_valid` with `bit_data=rx_s`.
      - If `rx_s==run_bit`, `run_cnt` increments (saturating).
      - If not, set `run_bit=rx_s`, `run_cnt=1`.
    - When `rec_cnt` reaches `IDLE_BITS`, go to IDLE. The triggering bit is still delivered.
- **Stuff-bit run rule.** A discarded stuff bit starts the next run. Stuff bits count towards `rec_cnt`.
- **`rx_sync_edge` gating.** Generated only in IDLE. Resynchronisation edges in other states are not this block's concern.

## Timing
- **Reset values:** all outputs 0, state INTEGRATE, counters 0, `run_bit=1`, synchroniser flops 1 (recessive).
- **Pin to `rx_s` latency:** 2 cycles.
- **Hard sync:** `rx_sync_edge` is registered, so it asserts the cycle after the edge appears on `rx_s`.
- **Sample-driven outputs:** `bit_valid`, `bit_data`, `sof` and `stuff_err` are registered and assert the cycle after the `sample_point` cycle. Each is high for exactly 1 cycle.
- **`bus_idle`:** registered. Rises the cycle after the transition into IDLE; falls the cycle after leaving IDLE.
- **`rst` mid-frame:** aborts immediately with no pulses. The block must re-integrate before it accepts a SOF.
- **Falling edge and `sample_point` in the same IDLE cycle:** both act. `rx_sync_edge` pulses and SOF is taken from `rx_s`.
- **`stuff_en` dropping exactly at `run_cnt==STUFF_LEN`:** no stuff check; the bit is delivered.
- **`sample_point` absent:** state, counters and data outputs hold.

## Structure
- **Shared package `can_pkg`:** state enum {INTEGRATE, IDLE, RECEIVE}, default constants `CAN_STUFF_LEN=5` and `CAN_IDLE_BITS=11`, and the `CAN_RECESSIVE=1'b1` constant.
- **Sub-module `can_rx_sync`:** 2-flop synchroniser plus previous-value register, outputting `rx_s` and `rx_fall`. It is reused by the TX bit monitor.

## Test plan
- **Integration:** after reset, hold `rx_in=1` for 10 sample points → `bus_idle=0`. On the 11th → `bus_idle=1`; `bit_valid`, `sof` and `stuff_err` never pulse.
- **SOF and hard sync:** from IDLE, drive `rx_in` 1→0 → one `rx_sync_edge` 3 cycles after the pin edge. Then one sample point → `sof=1`, `bit_valid=1`, `bit_data=0`, `bus_idle` falls.
- **Destuffing:** `stuff_en=1`, drive 0 (SOF),0,0,0,0,1(stuff),0,1 → `bit_valid` ×7 with data 0,0,0,0,0,0,1. The stuff bit is not delivered.
- **Stuff error:** `stuff_en=1`, drive six consecutive 0s from SOF → 5 `bit_valid`, then `stuff_err`. Eleven more recessive samples are needed before `bus_idle=1`.
- **Stuffing disabled:** `stuff_en=0`, drive 7 consecutive 1s mid-frame → 7 `bit_valid`, no `stuff_err`.
- **End of frame and reset:** 11 recessive samples in RECEIVE → `bus_idle=1`. `rst` asserted mid-frame → all outputs 0 the next cycle, state INTEGRATE.

Source files
------------

// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN receive-path types and constants
package can_pkg;

  typedef enum logic [1:0] {
    INTEGRATE,
    IDLE,
    RECEIVE
  } can_state_e;

  localparam int   CAN_STUFF_LEN = 5;
  localparam int   CAN_IDLE_BITS = 11;
  localparam logic CAN_RECESSIVE = 1'b1;

endpackage

// File: rtl/can_rx_sync.sv
// rtl/can_rx_sync.sv - 2-flop synchroniser for the CAN RX pin with falling-edge detect
module can_rx_sync
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic rx_fall
);

  logic rx_meta;
  logic rx_q;

  // Flops come out of reset recessive so no false edge is seen on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= CAN_RECESSIVE;
      rx_s    <= CAN_RECESSIVE;
      rx_q    <= CAN_RECESSIVE;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign rx_fall = rx_q & ~rx_s;

endmodule

// File: rtl/can_bit_destuff.sv
// rtl/can_bit_destuff.sv - CAN RX sampling, hard-sync generation and stuff-bit removal
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int IDLE_BITS = CAN_IDLE_BITS,
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic sample_point,
  input  logic stuff_en,
  output logic rx_sync_edge,
  output logic bit_valid,
  output logic bit_data,
  output logic sof,
  output logic stuff_err,
  output logic bus_idle
);

  localparam int REC_W = $clog2(IDLE_BITS + 1);
  localparam logic [REC_W-1:0] REC_MAX   = REC_W'(IDLE_BITS);
  localparam logic [2:0]       STUFF_MAX = 3'(STUFF_LEN);

  can_state_e       state;
  logic [REC_W-1:0] rec_cnt;
  logic [REC_W-1:0] rec_nxt;
  logic             rec_done;
  logic             run_bit;
  logic [2:0]       run_cnt;
  logic             rx_s;
  logic             rx_fall;

  can_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  always_comb begin
    rec_nxt = '0;
    if (rx_s) rec_nxt = (rec_cnt == REC_MAX) ? rec_cnt : rec_cnt + 1'b1;
    rec_done = sample_point && (rec_nxt == REC_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INTEGRATE;
      rec_cnt      <= '0;
      run_bit      <= 1'b1;
      run_cnt      <= '0;
      rx_sync_edge <= 1'b0;
      bit_valid    <= 1'b0;
      bit_data     <= 1'b0;
      sof          <= 1'b0;
      stuff_err    <= 1'b0;
      bus_idle     <= 1'b0;
    end else begin
      rx_sync_edge <= 1'b0;
      bit_valid    <= 1'b0;
      sof          <= 1'b0;
      stuff_err    <= 1'b0;

      if (sample_point) rec_cnt <= rec_nxt;
      if (state == IDLE && rx_fall) rx_sync_edge <= 1'b1;

      case (state)
        INTEGRATE: begin
          if (rec_done) begin
            state    <= IDLE;
            bus_idle <= 1'b1;
          end
        end
        IDLE: begin
          if (sample_point && !rx_s) begin
            sof       <= 1'b1;
            bit_valid <= 1'b1;
            bit_data  <= 1'b0;
            run_bit   <= 1'b0;
            run_cnt   <= 3'd1;
            state     <= RECEIVE;
            bus_idle  <= 1'b0;
          end
        end
        RECEIVE: begin
          if (sample_point) begin
            if (rec_done) begin
              state    <= IDLE;
              bus_idle <= 1'b1;
            end
            // A complementary stuff bit is dropped but still opens the next run.
            if (stuff_en && run_cnt == STUFF_MAX) begin
              if (rx_s == run_bit) begin
                stuff_err <= 1'b1;
                state     <= INTEGRATE;
                bus_idle  <= 1'b0;
              end else begin
                run_bit <= rx_s;
                run_cnt <= 3'd1;
              end
            end else begin
              bit_valid <= 1'b1;
              bit_data  <= rx_s;
              if (rx_s == run_bit) begin
                if (run_cnt != STUFF_MAX) run_cnt <= run_cnt + 3'd1;
              end else begin
                run_bit <= rx_s;
                run_cnt <= 3'd1;
              end
            end
          end
        end
        default: begin
          state    <= INTEGRATE;
          bus_idle <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_bit_destuff.sv
// tb/tb_can_bit_destuff.sv - directed self-checking bench for can_bit_destuff
module tb_can_bit_destuff;

  logic clk = 1'b0;
  logic rst, rx_in, sample_point, stuff_en;
  logic rx_sync_edge, bit_valid, bit_data, sof, stuff_err, bus_idle;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  can_bit_destuff dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .sample_point (sample_point),
    .stuff_en     (stuff_en),
    .rx_sync_edge (rx_sync_edge),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .sof          (sof),
    .stuff_err    (stuff_err),
    .bus_idle     (bus_idle)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a bit on the pin, let it cross the synchroniser, then pulse sample_point.
  task automatic do_sample(input logic v, input logic se,
                           output logic bv, output logic bd, output logic sf,
                           output logic er, output logic id, output logic ed,
                           output int stray);
    stray = 0;
    rx_in = v;
    stuff_en = se;
    sample_point = 1'b0;
    repeat (2) begin
      tick();
      if (bit_valid | sof | stuff_err | rx_sync_edge) stray++;
    end
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    bv = bit_valid; bd = bit_data; sf = sof; er = stuff_err; id = bus_idle; ed = rx_sync_edge;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; sample_point = 1'b0; stuff_en = 1'b0;
    repeat (3) tick();
    tests++;
    if ({rx_sync_edge, bit_valid, bit_data, sof, stuff_err, bus_idle} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {rx_sync_edge, bit_valid, bit_data, sof, stuff_err, bus_idle});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_integration();
    logic bv, bd, sf, er, id, ed;
    int stray;
    for (int i = 1; i <= 11; i++) begin
      do_sample(1'b1, 1'b0, bv, bd, sf, er, id, ed, stray);
      tests++;
      if (id !== (i == 11)) begin
        fails++;
        $display("FAIL integrate_idle[%0d]: bus_idle=%b expected %b", i, id, (i == 11));
      end
      tests++;
      if ({bv, sf, er, ed} !== 4'b0 || stray != 0) begin
        fails++;
        $display("FAIL integrate_pulses[%0d]: bv/sof/err/edge=%b stray=%0d expected 0000/0", i, {bv, sf, er, ed}, stray);
      end
    end
  endtask

  task automatic test_sof();
    logic [3:0] exp_edge;
    exp_edge = 4'b0100;
    rx_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (rx_sync_edge !== exp_edge[i]) begin
        fails++;
        $display("FAIL hard_sync[cycle %0d]: rx_sync_edge=%b expected %b", i + 1, rx_sync_edge, exp_edge[i]);
      end
    end
    stuff_en = 1'b1;
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
    tests++;
    if ({sof, bit_valid, bit_data, bus_idle} !== 4'b1100) begin
      fails++;
      $display("FAIL sof_bit: sof/valid/data/idle=%b expected 1100", {sof, bit_valid, bit_data, bus_idle});
    end
    tick();
    tests++;
    if ({sof, bit_valid} !== 2'b00) begin
      fails++;
      $display("FAIL sof_one_cycle: sof/valid=%b expected 00", {sof, bit_valid});
    end
  endtask

  task automatic test_stuff_disabled();
    logic bv, bd, sf, er, id, ed;
    int stray;
    for (int i = 0; i < 7; i++) begin
      do_sample(1'b1, 1'b0, bv, bd, sf, er, id, ed, stray);
      tests++;
      if ({bv, bd, sf, er, id} !== 5'b11000 || stray != 0) begin
        fails++;
        $display("FAIL nostuff_bit[%0d]: valid/data/sof/err/idle=%b stray=%0d expected 11000/0", i, {bv, bd, sf, er, id}, stray);
      end
    end
  endtask

  task automatic test_end_of_frame();
    logic bv, bd, sf, er, id, ed;
    int stray;
    for (int i = 8; i <= 11; i++) begin
      do_sample(1'b1, 1'b0, bv, bd, sf, er, id, ed, stray);
      tests++;
      if ({bv, bd, er, id} !== {3'b110, (i == 11)}) begin
        fails++;
        $display("FAIL eof_bit[%0d]: valid/data/err/idle=%b expected %b", i, {bv, bd, er, id}, {3'b110, (i == 11)});
      end
    end
  endtask

  task automatic test_destuff();
    logic bv, bd, sf, er, id, ed;
    int stray;
    logic [7:0] vals, exp_v;
    vals  = 8'b1010_0000;
    exp_v = 8'b1101_1111;
    for (int i = 0; i < 8; i++) begin
      do_sample(vals[i], 1'b1, bv, bd, sf, er, id, ed, stray);
      tests++;
      if (bv !== exp_v[i] || (exp_v[i] && bd !== vals[i]) || er !== 1'b0) begin
        fails++;
        $display("FAIL destuff[%0d]: valid=%b data=%b err=%b expected valid=%b data=%b err=0", i, bv, bd, er, exp_v[i], vals[i]);
      end
      tests++;
      if (sf !== (i == 0) || ed !== (i == 0) || stray != 0) begin
        fails++;
        $display("FAIL destuff_sof_edge[%0d]: sof=%b edge=%b stray=%0d expected %b %b 0", i, sf, ed, stray, (i == 0), (i == 0));
      end
    end
    for (int i = 0; i < 11; i++) do_sample(1'b1, 1'b0, bv, bd, sf, er, id, ed, stray);
    tests++;
    if (id !== 1'b1) begin
      fails++;
      $display("FAIL destuff_back_to_idle: bus_idle=%b expected 1", id);
    end
  endtask

  task automatic test_stuff_err();
    logic bv, bd, sf, er, id, ed;
    int stray;
    for (int i = 0; i < 6; i++) begin
      do_sample(1'b0, 1'b1, bv, bd, sf, er, id, ed, stray);
      tests++;
      if (bv !== (i < 5) || er !== (i == 5) || id !== 1'b0) begin
        fails++;
        $display("FAIL stuff_err[%0d]: valid=%b err=%b idle=%b expected %b %b 0", i, bv, er, id, (i < 5), (i == 5));
      end
    end
    tick();
    tests++;
    if (stuff_err !== 1'b0) begin
      fails++;
      $display("FAIL stuff_err_one_cycle: stuff_err=%b expected 0", stuff_err);
    end
    for (int i = 1; i <= 11; i++) begin
      do_sample(1'b1, 1'b1, bv, bd, sf, er, id, ed, stray);
      if (i >= 10) begin
        tests++;
        if (id !== (i == 11) || bv !== 1'b0) begin
          fails++;
          $display("FAIL reintegrate[%0d]: idle=%b valid=%b expected %b 0", i, id, bv, (i == 11));
        end
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic bv, bd, sf, er, id, ed;
    int stray;
    do_sample(1'b0, 1'b1, bv, bd, sf, er, id, ed, stray);
    do_sample(1'b1, 1'b1, bv, bd, sf, er, id, ed, stray);
    rx_in = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    sample_point = 1'b1;
    tick();
    rst = 1'b0;
    sample_point = 1'b0;
    tests++;
    if ({rx_sync_edge, bit_valid, bit_data, sof, stuff_err, bus_idle} !== 6'b0) begin
      fails++;
      $display("FAIL rst_mid_frame: outputs=%b expected 000000",
               {rx_sync_edge, bit_valid, bit_data, sof, stuff_err, bus_idle});
    end
    do_sample(1'b0, 1'b1, bv, bd, sf, er, id, ed, stray);
    tests++;
    if ({bv, sf, id, ed} !== 4'b0) begin
      fails++;
      $display("FAIL no_sof_before_integrate: valid/sof/idle/edge=%b expected 0000", {bv, sf, id, ed});
    end
    for (int i = 1; i <= 11; i++) begin
      do_sample(1'b1, 1'b0, bv, bd, sf, er, id, ed, stray);
      if (i >= 10) begin
        tests++;
        if (id !== (i == 11)) begin
          fails++;
          $display("FAIL rst_reintegrate[%0d]: idle=%b expected %b", i, id, (i == 11));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_integration();
    test_sof();
    test_stuff_disabled();
    test_end_of_frame();
    test_destuff();
    test_stuff_err();
    test_rst_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
